fc_l2_port_arbiter: RTL and testbench
=====================================

Name: fc_l2_port_arbiter

Overview:
- Shares one L2 TCDM-style master port among N_REQ requesters: FC core data port plus NB_HWPE_PORTS HWPE master ports.
- Sits between the fabric-controller subsystem and the L2 interconnect.
- Arbitrates requests round-robin and tracks outstanding transactions in an in-order ID FIFO.
- Routes each response back to the requester that issued it.

Parameters:
- N_REQ, 5, number of requesters; index 0 is the core data port, 1..N_REQ-1 are HWPE ports.
- MAX_OUTSTANDING, 4, depth of the outstanding-transaction ID FIFO; power of two, at least 2.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  N_REQ  per-requester request.
- add_i  in  N_REQ x ADDR_WIDTH  per-requester address.
- wen_i  in  N_REQ  per-requester write enable, active-low (1 = read).
- wdata_i  in  N_REQ x DATA_WIDTH  per-requester write data.
- be_i  in  N_REQ x DATA_WIDTH/8  per-requester byte enables.
- gnt_o  out  N_REQ  per-requester grant.
- r_valid_o  out  N_REQ  per-requester response valid.
- r_rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters.
- r_opc_o  out  1  response error, broadcast to all requesters.
- l2_req_o  out  1  downstream request.
- l2_add_o  out  ADDR_WIDTH  downstream address.
- l2_wen_o  out  1  downstream write enable, active-low.
- l2_wdata_o  out  DATA_WIDTH  downstream write data.
- l2_be_o  out  DATA_WIDTH/8  downstream byte enables.
- l2_gnt_i  in  1  downstream grant.
- l2_r_valid_i  in  1  downstream response valid.
- l2_r_rdata_i  in  DATA_WIDTH  downstream response data.
- l2_r_opc_i  in  1  downstream response error.
- busy_o  out  1  high while the FIFO holds at least one outstanding transaction.

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous and active-high. All state is cleared on a clk_i edge while rst_i=1.
- Reset values:
  - Round-robin pointer = 0.
  - FIFO empty, count = 0; busy_o=0.
  - gnt_o=0, r_valid_o=0.
  - l2_req_o=0 while rst_i=1.
- Arbitration (combinational, same cycle):
  - Winner = first requester with req_i set, searching from rr_ptr upward with wrap.
  - The winner's add/wen/wdata/be drive the l2_* outputs.
  - l2_req_o = (any req_i) and not fifo_full.
- Acceptance: a transfer is accepted when l2_req_o and l2_gnt_i are both high.
  - gnt_o[winner] = l2_gnt_i and l2_req_o, asserted the same cycle.
  - All other gnt_o bits are 0.
  - On acceptance, the winner index is pushed into the FIFO and rr_ptr becomes winner+1 mod N_REQ.
  - Without acceptance, rr_ptr holds. A requester that holds req_i keeps its priority position and is served within N_REQ accepted transfers.
- Response routing:
  - Downstream returns exactly one response per accepted request, in order, no earlier than the cycle after the grant.
  - On l2_r_valid_i, r_valid_o[fifo_head]=1 that cycle, and the FIFO pops.
  - r_rdata_o and r_opc_o pass through combinationally from l2_r_rdata_i and l2_r_opc_i.
- Boundary conditions:
  - FIFO full: l2_req_o=0. This holds even if a pop occurs the same cycle; no bypass, which gives a one-cycle bubble.
  - Push and pop in the same cycle when not full: count is unchanged and both pointers advance.
  - l2_r_valid_i with an empty FIFO: protocol violation. No r_valid_o is asserted and the count does not underflow. A simulation assertion flags it.
  - A requester that drops req_i after losing arbitration is allowed; it is not remembered.
  - Reset mid-transaction: outstanding IDs are discarded and later stray responses are ignored. The FIFO is empty after reset, so the empty-FIFO rule applies.
- Latency: zero-cycle request path. Response path is combinational, zero added cycles.
- Pointer arithmetic:
  - Read and write pointers are $clog2(MAX_OUTSTANDING) bits and wrap naturally.
  - Count is $clog2(MAX_OUTSTANDING)+1 bits.
  - rr_ptr wraps from N_REQ-1 to 0 and is a $clog2(N_REQ)-bit value with explicit wrap.

Decomposition:
- Package fc_l2_arb_pkg:
  - Typedef req_id_t = logic [$clog2(N_REQ_MAX)-1:0], with N_REQ_MAX=16.
  - Localparams for default depth and widths.
  - A function rr_pick(req, ptr) returning the winner index.
- Sub-module fc_l2_arb_id_fifo: synchronous FIFO of req_id_t with push, pop, full, empty, head and count outputs. Parameter DEPTH. Synchronous active-high reset.

Test Plan:
1. Single requester: req_i=5'b00001, l2_gnt_i=1, add 0x1C000010 → l2_add_o=0x1C000010 and gnt_o=00001 the same cycle. Response one cycle later with rdata 0xDEADBEEF → r_valid_o=00001, r_rdata_o=0xDEADBEEF.
2. Round-robin: all five req_i held high with l2_gnt_i=1 for 10 cycles → grant order 0,1,2,3,4,0,1,2,3,4.
3. Backpressure: l2_gnt_i=0 for 3 cycles while req_i=00110 → gnt_o=0 and rr_ptr unchanged. Next gnt → requester 1 granted first.
4. FIFO full: 4 grants with no responses → l2_req_o=0 on the 5th cycle and busy_o=1. A response arriving the same cycle → still no grant. Next cycle → grant resumes.
5. Out-of-phase routing: grant requester 3 then requester 1; responses 0xA then 0xB → r_valid_o=01000 with 0xA, then 00010 with 0xB.
6. Reset mid-operation: 2 outstanding, rst_i=1 for 1 cycle → busy_o=0, rr_ptr=0. A following stray l2_r_valid_i → r_valid_o stays 0.

Source files
------------

// File: rtl/fc_l2_arb_pkg.sv
// Shared types and helpers for the FC L2 port arbiter.
// Requester IDs are sized for up to 16 ports.
package fc_l2_arb_pkg;

    localparam int N_REQ_MAX = 16;
    localparam int DEF_N_REQ = 5;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_AW    = 32;
    localparam int DEF_DW    = 32;

    typedef logic [$clog2(N_REQ_MAX)-1:0] req_id_t;

    // First set request at or after ptr, wrapping at n.
    function automatic req_id_t rr_pick(
        input logic [N_REQ_MAX-1:0] req,
        input req_id_t              ptr,
        input int                   n
    );
        req_id_t     win;
        logic        found;
        int unsigned idx;
        win   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ_MAX; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= 32'(n)) idx = idx - 32'(n);
            if (i < 32'(n) && !found && req[req_id_t'(idx)]) begin
                win   = req_id_t'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/fc_l2_arb_if.sv
// Requester-side and L2-side bus bundle of the arbiter.
// slave = arbiter view, master = requesters plus L2 model.
interface fc_l2_arb_if
    import fc_l2_arb_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int ADDR_WIDTH = DEF_AW,
    parameter int DATA_WIDTH = DEF_DW
);
    logic [N_REQ-1:0]                   req_i;
    logic [N_REQ-1:0][ADDR_WIDTH-1:0]   add_i;
    logic [N_REQ-1:0]                   wen_i;
    logic [N_REQ-1:0][DATA_WIDTH-1:0]   wdata_i;
    logic [N_REQ-1:0][DATA_WIDTH/8-1:0] be_i;
    logic [N_REQ-1:0]                   gnt_o;
    logic [N_REQ-1:0]                   r_valid_o;
    logic [DATA_WIDTH-1:0]              r_rdata_o;
    logic                               r_opc_o;
    logic                               l2_req_o;
    logic [ADDR_WIDTH-1:0]              l2_add_o;
    logic                               l2_wen_o;
    logic [DATA_WIDTH-1:0]              l2_wdata_o;
    logic [DATA_WIDTH/8-1:0]            l2_be_o;
    logic                               l2_gnt_i;
    logic                               l2_r_valid_i;
    logic [DATA_WIDTH-1:0]              l2_r_rdata_i;
    logic                               l2_r_opc_i;

    modport slave (
        input  req_i, add_i, wen_i, wdata_i, be_i,
        output gnt_o, r_valid_o, r_rdata_o, r_opc_o,
        output l2_req_o, l2_add_o, l2_wen_o, l2_wdata_o, l2_be_o,
        input  l2_gnt_i, l2_r_valid_i, l2_r_rdata_i, l2_r_opc_i
    );

    modport master (
        output req_i, add_i, wen_i, wdata_i, be_i,
        input  gnt_o, r_valid_o, r_rdata_o, r_opc_o,
        input  l2_req_o, l2_add_o, l2_wen_o, l2_wdata_o, l2_be_o,
        output l2_gnt_i, l2_r_valid_i, l2_r_rdata_i, l2_r_opc_i
    );
endinterface

// File: rtl/fc_l2_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding L2 transactions.
// Push when full and pop when empty are ignored.
module fc_l2_arb_id_fifo
    import fc_l2_arb_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  req_id_t                id_i,
    input  logic                   pop_i,
    output req_id_t                head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    req_id_t       mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = do_push ? wr_q + PW'(1) : wr_q;
        rd_d  = do_pop ? rd_q + PW'(1) : rd_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + (PW+1)'(1);
        if (do_pop && !do_push) cnt_d = cnt_q - (PW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) mem_q[wr_q] <= id_i;
    end

endmodule

// File: rtl/fc_l2_port_arbiter.sv
// Round-robin share of one L2 master port among FC core and HWPE ports,
// with in-order response routing through an outstanding-ID FIFO.
module fc_l2_port_arbiter
    import fc_l2_arb_pkg::*;
#(
    parameter int N_REQ           = DEF_N_REQ,
    parameter int MAX_OUTSTANDING = DEF_DEPTH,
    parameter int ADDR_WIDTH      = DEF_AW,
    parameter int DATA_WIDTH      = DEF_DW
) (
    input  logic        clk_i,
    input  logic        rst_i,
    fc_l2_arb_if.slave  bus,
    output logic        busy_o
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    logic [PW-1:0] rr_q, rr_d, win;
    req_id_t       win_id, head;
    logic          full, empty, accept, pop;
    logic          stray_ok_q;
    logic [CW-1:0] count;

    assign win_id = rr_pick(N_REQ_MAX'(bus.req_i), req_id_t'(rr_q), N_REQ);
    assign win    = PW'(win_id);

    assign bus.l2_req_o   = (|bus.req_i) & ~full & ~rst_i;
    assign bus.l2_add_o   = bus.add_i[win];
    assign bus.l2_wen_o   = bus.wen_i[win];
    assign bus.l2_wdata_o = bus.wdata_i[win];
    assign bus.l2_be_o    = bus.be_i[win];
    assign bus.r_rdata_o  = bus.l2_r_rdata_i;
    assign bus.r_opc_o    = bus.l2_r_opc_i;

    assign accept = bus.l2_req_o & bus.l2_gnt_i;
    assign pop    = bus.l2_r_valid_i & ~empty & ~rst_i;
    assign busy_o = (count != '0);

    always_comb begin
        bus.gnt_o     = '0;
        bus.r_valid_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.gnt_o[i]     = accept && (win == PW'(i));
            bus.r_valid_o[i] = pop && (head == req_id_t'(i));
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (accept) rr_d = (win == PW'(N_REQ-1)) ? '0 : win + PW'(1);
    end

    // After reset, responses to discarded IDs may still trickle in.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            stray_ok_q <= 1'b1;
        end else begin
            rr_q       <= rr_d;
            stray_ok_q <= stray_ok_q & ~accept;
            if (!stray_ok_q)
                assert (!(bus.l2_r_valid_i && empty))
                else $error("l2_r_valid_i with no outstanding transaction");
        end
    end

    fc_l2_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .id_i    (req_id_t'(win)),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Bench for fc_l2_port_arbiter: directed scenarios plus random traffic,
// all outputs compared every cycle against a queue-based model.
module tb_fc_l2_port_arbiter;
    localparam int N = 5;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   n_vec = 0;
    int   n_err = 0;
    int   m_rr = 0;
    int   m_q[$];

    always #5 clk = ~clk;

    fc_l2_arb_if #(.N_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bif();

    fc_l2_port_arbiter #(
        .N_REQ(N), .MAX_OUTSTANDING(D), .ADDR_WIDTH(32), .DATA_WIDTH(32)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bif.slave),
        .busy_o (busy)
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model: rr pointer plus a queue of outstanding requester indices.
    initial begin
        int w;
        bit e_req, acc, pv, r_s;
        logic [N-1:0] e_gnt, e_rv;
        forever begin
            @(negedge clk);
            r_s = rst;
            w = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_rr + k) % N;
                if (w < 0 && bif.req_i[j]) w = j;
            end
            e_req = (w >= 0) && (m_q.size() < D) && !r_s;
            acc   = e_req && bif.l2_gnt_i;
            e_gnt = acc ? (N'(1) << w) : '0;
            pv    = bif.l2_r_valid_i && (m_q.size() > 0) && !r_s;
            e_rv  = pv ? (N'(1) << m_q[0]) : '0;
            chk("l2_req", bif.l2_req_o, e_req);
            chk("gnt", bif.gnt_o, e_gnt);
            chk("r_valid", bif.r_valid_o, e_rv);
            chk("busy", busy, m_q.size() > 0);
            chk("r_rdata", bif.r_rdata_o, bif.l2_r_rdata_i);
            chk("r_opc", bif.r_opc_o, bif.l2_r_opc_i);
            if (e_req) begin
                chk("l2_add", bif.l2_add_o, bif.add_i[w]);
                chk("l2_wen", bif.l2_wen_o, bif.wen_i[w]);
                chk("l2_wdata", bif.l2_wdata_o, bif.wdata_i[w]);
                chk("l2_be", bif.l2_be_o, bif.be_i[w]);
            end
            @(posedge clk);
            if (r_s) begin
                m_rr = 0;
                m_q.delete();
            end else begin
                if (pv) void'(m_q.pop_front());
                if (acc) begin
                    m_q.push_back(w);
                    m_rr = (w + 1) % N;
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bif.req_i        = '0;
        bif.add_i        = '0;
        bif.wen_i        = '1;
        bif.wdata_i      = '0;
        bif.be_i         = '1;
        bif.l2_gnt_i     = 1'b0;
        bif.l2_r_valid_i = 1'b0;
        bif.l2_r_rdata_i = '0;
        bif.l2_r_opc_i   = 1'b0;

        @(negedge clk);
        chk("rst_gnt", bif.gnt_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_l2_req", bif.l2_req_o, 0);
        nxt();
        rst = 1'b0;

        // single requester
        bif.req_i    = 5'b00001;
        bif.add_i[0] = 32'h1C000010;
        bif.l2_gnt_i = 1'b1;
        @(negedge clk);
        chk("t1_add", bif.l2_add_o, 64'h1C000010);
        chk("t1_gnt", bif.gnt_o, 5'b00001);
        nxt();
        bif.req_i        = '0;
        bif.l2_r_valid_i = 1'b1;
        bif.l2_r_rdata_i = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_rvalid", bif.r_valid_o, 5'b00001);
        chk("t1_rdata", bif.r_rdata_o, 64'hDEADBEEF);
        nxt();
        bif.l2_r_valid_i = 1'b0;
        rst = 1'b1;
        nxt();
        rst = 1'b0;

        // round robin over all five
        bif.req_i = 5'b11111;
        for (int i = 0; i < 10; i++) begin
            bif.l2_r_valid_i = (i > 0);
            @(negedge clk);
            chk("t2_order", bif.gnt_o, 64'(1) << (i % 5));
            nxt();
        end
        bif.req_i = '0;
        nxt();
        bif.l2_r_valid_i = 1'b0;

        // backpressure
        bif.req_i    = 5'b00110;
        bif.l2_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold", bif.gnt_o, 0);
            nxt();
        end
        bif.l2_gnt_i = 1'b1;
        @(negedge clk);
        chk("t3_first", bif.gnt_o, 5'b00010);
        nxt();
        bif.req_i        = '0;
        bif.l2_r_valid_i = 1'b1;
        nxt();
        bif.l2_r_valid_i = 1'b0;

        // fill the FIFO, rr starts at 2
        bif.req_i = 5'b11111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_fill", bif.gnt_o, 64'(1) << ((2 + i) % 5));
            nxt();
        end
        bif.l2_r_valid_i = 1'b1;
        @(negedge clk);
        chk("t4_full_req", bif.l2_req_o, 0);
        chk("t4_full_busy", busy, 1);
        chk("t4_full_gnt", bif.gnt_o, 0);
        chk("t4_pop", bif.r_valid_o, 5'b00100);
        nxt();
        bif.l2_r_valid_i = 1'b0;
        @(negedge clk);
        chk("t4_resume", bif.gnt_o, 5'b00010);
        nxt();
        bif.req_i        = '0;
        bif.l2_r_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) nxt();
        bif.l2_r_valid_i = 1'b0;

        // out-of-phase routing, rr at 2
        bif.req_i = 5'b01010;
        @(negedge clk);
        chk("t5_g3", bif.gnt_o, 5'b01000);
        nxt();
        bif.req_i = 5'b00010;
        @(negedge clk);
        chk("t5_g1", bif.gnt_o, 5'b00010);
        nxt();
        bif.req_i        = '0;
        bif.l2_r_valid_i = 1'b1;
        bif.l2_r_rdata_i = 32'hA;
        @(negedge clk);
        chk("t5_rv3", bif.r_valid_o, 5'b01000);
        chk("t5_rdA", bif.r_rdata_o, 64'hA);
        nxt();
        bif.l2_r_rdata_i = 32'hB;
        @(negedge clk);
        chk("t5_rv1", bif.r_valid_o, 5'b00010);
        chk("t5_rdB", bif.r_rdata_o, 64'hB);
        nxt();
        bif.l2_r_valid_i = 1'b0;

        // reset with two outstanding
        bif.req_i = 5'b00001;
        nxt();
        nxt();
        bif.req_i = '0;
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        for (int i = 0; i < N; i++) bif.add_i[i] = 32'h100 + 32'(i);
        bif.req_i    = 5'b11111;
        bif.l2_gnt_i = 1'b0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_rr0", bif.l2_add_o, 64'h100);
        nxt();
        bif.req_i        = '0;
        bif.l2_r_valid_i = 1'b1;
        @(negedge clk);
        chk("t6_stray", bif.r_valid_o, 0);
        nxt();
        bif.l2_r_valid_i = 1'b0;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 199) == 0);
            bif.req_i    = N'($urandom);
            for (int i = 0; i < N; i++) begin
                bif.add_i[i]   = $urandom;
                bif.wdata_i[i] = $urandom;
                bif.be_i[i]    = 4'($urandom);
            end
            bif.wen_i        = N'($urandom);
            bif.l2_gnt_i     = ($urandom_range(0, 3) != 0);
            bif.l2_r_valid_i = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
            bif.l2_r_rdata_i = $urandom;
            bif.l2_r_opc_i   = 1'($urandom);
            nxt();
        end
        rst = 1'b0;
        bif.req_i        = '0;
        bif.l2_r_valid_i = 1'b0;
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
